// File: rtl/screen_driver.sv
// screen_driver: 800x480 scan-out of a 4bpp framebuffer to VGA and LCD outputs through a 16-colour palette.
// Build option SCREEN_DRIVER_TEST_PATTERN_EN replaces framebuffer pixels with eight vertical colour bars.
module screen_driver (
  input  logic        clock,
  input  logic        reset,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [4:0]  vga_red,
  output logic [4:0]  vga_green,
  output logic [4:0]  vga_blue,
  output logic        lcd_de,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic [7:0]  lcd_red,
  output logic [7:0]  lcd_green,
  output logic [7:0]  lcd_blue,
  output logic [18:0] fb_addr,
  input  logic [3:0]  fb_data
);

  localparam int unsigned H_TOTAL      = 1056;
  localparam int unsigned H_ACTIVE     = 800;
  localparam int unsigned H_SYNC_START = 840;
  localparam int unsigned H_SYNC_END   = 967;
  localparam int unsigned V_TOTAL      = 525;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned V_SYNC_START = 493;
  localparam int unsigned V_SYNC_END   = 495;

  function automatic logic [23:0] palette(input logic [3:0] idx);
    logic [23:0] rgb;
    case (idx)
      4'd0:    rgb = 24'h000000;
      4'd1:    rgb = 24'h0000AA;
      4'd2:    rgb = 24'h00AA00;
      4'd3:    rgb = 24'h00AAAA;
      4'd4:    rgb = 24'hAA0000;
      4'd5:    rgb = 24'hAA00AA;
      4'd6:    rgb = 24'hAA5500;
      4'd7:    rgb = 24'hAAAAAA;
      4'd8:    rgb = 24'h555555;
      4'd9:    rgb = 24'h5555FF;
      4'd10:   rgb = 24'h55FF55;
      4'd11:   rgb = 24'h55FFFF;
      4'd12:   rgb = 24'hFF5555;
      4'd13:   rgb = 24'hFF55FF;
      4'd14:   rgb = 24'hFFFF55;
      default: rgb = 24'hFFFFFF;
    endcase
    return rgb;
  endfunction

  // Shared timing generator
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        active, hsync_n, vsync_n;

  always_comb begin
    h_d = h_q + 11'd1;
    v_d = v_q;
    if (h_q == 11'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign active  = (h_q < 11'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
  assign hsync_n = !((h_q >= 11'(H_SYNC_START)) && (h_q <= 11'(H_SYNC_END)));
  assign vsync_n = !((v_q >= 10'(V_SYNC_START)) && (v_q <= 10'(V_SYNC_END)));
  assign fb_addr = active ? (19'(v_q) * 19'd800 + 19'(h_q)) : '0;

  // Stage 1 tracks the RAM read so timing stays aligned with fb_data
  logic act1_q, hs1_q, vs1_q;
  logic [3:0] pix_idx;

`ifdef SCREEN_DRIVER_TEST_PATTERN_EN
  logic [2:0] bar1_q, bar_d;
  logic       unused_fb;

  always_comb begin
    bar_d = '0;
    for (int i = 1; i < 8; i++) begin
      if (h_q >= 11'(i * 100)) bar_d = 3'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) bar1_q <= '0;
    else       bar1_q <= bar_d;
  end

  assign unused_fb = ^fb_data;
  assign pix_idx   = {1'b0, bar1_q};
`else
  assign pix_idx = fb_data;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
    end else begin
      act1_q <= active;
      hs1_q  <= hsync_n;
      vs1_q  <= vsync_n;
    end
  end

  // Stage 2: palette lookup and output registers
  logic [23:0] colour_q, colour_d;
  logic        de_q, hs_q, vs_q;

  always_comb begin
    colour_d = act1_q ? palette(pix_idx) : 24'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      colour_q <= '0;
      de_q     <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      colour_q <= colour_d;
      de_q     <= act1_q;
      hs_q     <= hs1_q;
      vs_q     <= vs1_q;
    end
  end

  assign lcd_red   = colour_q[23:16];
  assign lcd_green = colour_q[15:8];
  assign lcd_blue  = colour_q[7:0];
  assign vga_red   = colour_q[23:19];
  assign vga_green = colour_q[15:11];
  assign vga_blue  = colour_q[7:3];
  assign lcd_de    = de_q;
  assign lcd_hsync = hs_q;
  assign lcd_vsync = vs_q;
  assign vga_hsync = hs_q;
  assign vga_vsync = vs_q;

endmodule

// File: tb/tb_screen_driver.sv
// tb_screen_driver: randomized framebuffer contents checked against a frame-position reference model.
// Model predicts each output from the pixel position implied by clocks elapsed since reset release.
module tb_screen_driver;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        vga_hsync, vga_vsync, lcd_de, lcd_hsync, lcd_vsync;
  logic [4:0]  vga_red, vga_green, vga_blue;
  logic [7:0]  lcd_red, lcd_green, lcd_blue;
  logic [18:0] fb_addr;
  logic [3:0]  fb_data = 4'd0;

  logic [3:0]  mem [0:383999];
  logic [23:0] pal [0:15];
  int total = 0;
  int bad   = 0;
  int n     = 0;

  localparam logic [43:0] BLANK = {1'b1, 1'b1, 15'd0, 1'b0, 1'b1, 1'b1, 24'd0};

  logic [43:0] obs;
  assign obs = {vga_hsync, vga_vsync, vga_red, vga_green, vga_blue,
                lcd_de, lcd_hsync, lcd_vsync, lcd_red, lcd_green, lcd_blue};

  screen_driver dut (
    .clock(clock), .reset(reset),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
    .lcd_red(lcd_red), .lcd_green(lcd_green), .lcd_blue(lcd_blue),
    .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (fb_addr < 19'd384000) fb_data <= mem[fb_addr];
    else                      fb_data <= 4'bxxxx;
  end

  // Expected outputs n clocks after reset release: they show pixel position n-2.
  function automatic logic [43:0] exp_out(input int k);
    int p, h, v;
    logic hs, vs, de;
    logic [3:0] idx;
    logic [23:0] c;
    if (k < 2) return BLANK;
    p  = k - 2;
    h  = p % 1056;
    v  = (p / 1056) % 525;
    de = (h < 800) && (v < 480);
    hs = !(h >= 840 && h < 968);
    vs = !(v >= 493 && v < 496);
    c  = 24'd0;
    if (de) begin
`ifdef SCREEN_DRIVER_TEST_PATTERN_EN
      idx = 4'(h / 100);
`else
      idx = mem[v * 800 + h];
`endif
      c = pal[idx];
    end
    return {hs, vs, c[23:19], c[15:11], c[7:3], de, hs, vs, c};
  endfunction

  function automatic logic [18:0] exp_addr(input int k);
    int h, v;
    h = k % 1056;
    v = (k / 1056) % 525;
    if (h < 800 && v < 480) return 19'(v * 800 + h);
    return 19'd0;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 384000; i++) mem[i] = 4'($urandom_range(0, 15));
  endtask

  task automatic restart();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n = 0;
  endtask

  task automatic advance_to(input int target);
    while (n < target) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run_check(input int cycles, input string tag);
    int errs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      n++;
      total++;
      if (obs !== exp_out(n) || fb_addr !== exp_addr(n)) begin
        bad++;
        errs++;
        $display("FAIL %s n=%0d out=%h addr=%0d required out=%h addr=%0d",
                 tag, n, obs, fb_addr, exp_out(n), exp_addr(n));
        if (errs >= 10) break;
      end
    end
    $display("%s: %0d cycles compared, %0d errors", tag, cycles, errs);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      total++;
      if (obs !== BLANK || fb_addr !== 19'd0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d out=%h addr=%0d required out=%h addr=0", i, obs, fb_addr, BLANK);
      end
    end
    reset = 1'b0;
    n = 0;
    @(negedge clock); n++;
    total++;
    if (lcd_de !== 1'b0) begin
      bad++;
      $display("FAIL de_after_1 got %b required 0", lcd_de);
    end
    @(negedge clock); n++;
    total++;
    if (lcd_de !== 1'b1) begin
      bad++;
      $display("FAIL de_after_2 got %b required 1", lcd_de);
    end
    $display("test_reset done");
  endtask

  task automatic test_addr();
    int targets [6] = '{0, 799, 800, 1056, 2056, 2117};
    logic [18:0] want [6] = '{19'd0, 19'd799, 19'd0, 19'd800, 19'd0, 19'd1605};
    restart();
    for (int i = 0; i < 6; i++) begin
      advance_to(targets[i]);
      total++;
      if (fb_addr !== want[i]) begin
        bad++;
        $display("FAIL fb_addr n=%0d got %0d required %0d", targets[i], fb_addr, want[i]);
      end
    end
    $display("test_addr done");
  endtask

  task automatic test_line_counts();
    int hs_low = 0, de_high = 0, run = 0, max_run = 0;
    restart();
    advance_to(2);
    for (int i = 0; i < 3 * 1056; i++) begin
      if (lcd_hsync === 1'b0) begin hs_low++; run++; end
      else run = 0;
      if (run > max_run) max_run = run;
      if (lcd_de === 1'b1) de_high++;
      @(negedge clock); n++;
    end
    total++;
    if (hs_low !== 384) begin
      bad++;
      $display("FAIL hsync_low_count got %0d required 384", hs_low);
    end
    total++;
    if (max_run !== 128) begin
      bad++;
      $display("FAIL hsync_width got %0d required 128", max_run);
    end
    total++;
    if (de_high !== 2400) begin
      bad++;
      $display("FAIL de_count got %0d required 2400", de_high);
    end
    $display("test_line_counts: hs_low=%0d width=%0d de=%0d", hs_low, max_run, de_high);
  endtask

  task automatic test_colour14();
    for (int i = 0; i < 384000; i++) mem[i] = (i < 192000) ? 4'd14 : 4'd0;
    restart();
    advance_to(2 + 1056 + 100);
    total++;
    if ({lcd_red, lcd_green, lcd_blue, vga_red, vga_green, vga_blue} !==
        {24'hFFFF55, 5'd31, 5'd31, 5'd10}) begin
      bad++;
      $display("FAIL colour14 got lcd=%h%h%h vga=%0d/%0d/%0d required lcd=FFFF55 vga=31/31/10",
               lcd_red, lcd_green, lcd_blue, vga_red, vga_green, vga_blue);
    end
    advance_to(2 + 1056 + 850);
    total++;
    if ({lcd_red, lcd_green, lcd_blue, vga_red, vga_green, vga_blue} !== 39'd0) begin
      bad++;
      $display("FAIL blank_rgb got lcd=%h%h%h vga=%0d/%0d/%0d required all 0",
               lcd_red, lcd_green, lcd_blue, vga_red, vga_green, vga_blue);
    end
    run_check(1056, "colour14_run");
  endtask

  task automatic test_mid_reset();
    fill_random();
    restart();
    run_check(2 * 1056 + 500, "pre_reset_run");
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs !== BLANK || fb_addr !== 19'd0) begin
      bad++;
      $display("FAIL mid_reset_blank out=%h addr=%0d required out=%h addr=0", obs, fb_addr, BLANK);
    end
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    run_check(1100, "post_reset_run");
  endtask

`ifdef SCREEN_DRIVER_TEST_PATTERN_EN
  task automatic test_pattern();
    fill_random();
    restart();
    advance_to(2 + 250);
    total++;
    if ({lcd_red, lcd_green, lcd_blue, vga_red, vga_green, vga_blue} !==
        {24'h00AA00, 5'd0, 5'd21, 5'd0}) begin
      bad++;
      $display("FAIL pattern_x250 got lcd=%h%h%h vga=%0d/%0d/%0d required lcd=00AA00 vga=0/21/0",
               lcd_red, lcd_green, lcd_blue, vga_red, vga_green, vga_blue);
    end
    run_check(1100, "pattern_run");
  endtask
`endif

  initial begin
    pal = '{24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
            24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
            24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
            24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF};
    fill_random();
    test_reset();
    run_check(2 * 1056, "free_run");
    test_addr();
    test_line_counts();
    test_colour14();
    test_mid_reset();
`ifdef SCREEN_DRIVER_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
